// File: rtl/input_fetcher.sv
// input_fetcher: gathers a KERNEL x KERNEL pixel window from a single-port
// pixel memory, zero-filling positions that fall outside the image, and
// presents it to a controller over a four-phase req/ready handshake.
module input_fetcher #(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned KERNEL            = 3,
    parameter int unsigned IMG_W             = 16,
    parameter int unsigned IMG_H             = 16,
    parameter int unsigned ADDR_WIDTH        = 8,
    parameter int unsigned INPUT_WIDTH_LOG   = $clog2(IMG_W),
    parameter int unsigned INPUT_HEIGHT_LOG  = $clog2(IMG_H)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 input_req,
    input  logic [INPUT_WIDTH_LOG-1:0]           width_index,
    input  logic [INPUT_HEIGHT_LOG-1:0]          height_index,
    output logic                                 input_ready,
    output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  window_data,
    output logic                                 mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    input  logic [DATA_WIDTH-1:0]                mem_rd_data,
    input  logic                                 mem_rd_valid
);

    localparam int unsigned WORDS  = KERNEL * KERNEL;
    localparam int unsigned K_W    = $clog2(WORDS + 1);
    localparam int unsigned RC_W   = $clog2(KERNEL + 1);
    localparam int unsigned IDX_W  = (INPUT_WIDTH_LOG > INPUT_HEIGHT_LOG) ? INPUT_WIDTH_LOG : INPUT_HEIGHT_LOG;
    // One spare bit so index + kernel offset never wraps back into the image.
    localparam int unsigned SUM_W  = ((IDX_W > RC_W) ? IDX_W : RC_W) + 1;
    localparam int unsigned CALC_W = 32;
    localparam int unsigned WIN_W  = WORDS * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        READY     = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [INPUT_WIDTH_LOG-1:0]   r_wi;
    logic [INPUT_HEIGHT_LOG-1:0]  r_hi;
    logic [K_W-1:0]               r_k;
    logic [RC_W-1:0]              r_kr;
    logic [RC_W-1:0]              r_kc;
    logic [WIN_W-1:0]             r_window;
    logic                         r_rd_en;
    logic [ADDR_WIDTH-1:0]        r_addr;
    logic                         r_ready;

    logic [SUM_W-1:0]             w_row;
    logic [SUM_W-1:0]             w_col;
    logic                         w_in_img;
    logic                         w_last;
    logic [ADDR_WIDTH-1:0]        w_addr_calc;
    logic                         w_accept;
    logic                         w_advance;
    logic [DATA_WIDTH-1:0]        w_word;
    logic                         w_rd_en_c;
    logic [ADDR_WIDTH-1:0]        w_addr_c;
    logic                         w_ready_c;

    // Image coordinates of the current window word and its bounds test.
    always_comb begin
        w_row       = SUM_W'(r_hi) + SUM_W'(r_kr);
        w_col       = SUM_W'(r_wi) + SUM_W'(r_kc);
        w_in_img    = (w_row < SUM_W'(IMG_H)) && (w_col < SUM_W'(IMG_W));
        w_last      = (r_k == K_W'(WORDS - 1));
        w_addr_calc = ADDR_WIDTH'(CALC_W'(w_row) * CALC_W'(IMG_W) + CALC_W'(w_col));
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_word      = '0;
        w_rd_en_c   = 1'b0;
        w_addr_c    = r_addr;
        w_ready_c   = 1'b0;
        case (r_state)
            IDLE: begin
                if (input_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_in_img) begin
                    w_rd_en_c   = 1'b1;
                    w_addr_c    = w_addr_calc;
                    w_state_nxt = WAIT_DATA;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = w_last ? READY : ISSUE;
                end
            end
            WAIT_DATA: begin
                if (mem_rd_valid) begin
                    w_advance   = 1'b1;
                    w_word      = mem_rd_data;
                    w_state_nxt = w_last ? READY : ISSUE;
                end
            end
            READY: begin
                w_ready_c = 1'b1;
                if (!input_req) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched indices, word counters, window storage and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wi     <= '0;
            r_hi     <= '0;
            r_k      <= '0;
            r_kr     <= '0;
            r_kc     <= '0;
            r_window <= '0;
            r_rd_en  <= 1'b0;
            r_addr   <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_rd_en <= w_rd_en_c;
            r_addr  <= w_addr_c;
            r_ready <= w_ready_c;
            if (w_accept) begin
                r_wi <= width_index;
                r_hi <= height_index;
                r_k  <= '0;
                r_kr <= '0;
                r_kc <= '0;
            end else if (w_advance) begin
                r_window[int'(r_k)*DATA_WIDTH +: DATA_WIDTH] <= w_word;
                r_k <= r_k + K_W'(1);
                if (r_kc == RC_W'(KERNEL - 1)) begin
                    r_kc <= '0;
                    r_kr <= r_kr + RC_W'(1);
                end else begin
                    r_kc <= r_kc + RC_W'(1);
                end
            end
        end
    end

    assign input_ready = r_ready;
    assign window_data = r_window;
    assign mem_rd_en   = r_rd_en;
    assign mem_addr    = r_addr;

endmodule

// File: tb/tb_input_fetcher.sv
// Bench for input_fetcher: a latency-programmable pixel memory plus a window
// model computed directly from image coordinates.
module tb_input_fetcher;

    localparam int unsigned DW    = 8;
    localparam int unsigned K     = 3;
    localparam int unsigned IW    = 16;
    localparam int unsigned IH    = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned WIN_W = K * K * DW;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             input_req = 1'b0;
    logic [3:0]       width_index = '0;
    logic [3:0]       height_index = '0;
    logic             input_ready;
    logic [WIN_W-1:0] window_data;
    logic             mem_rd_en;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_rd_data = '0;
    logic             mem_rd_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [256];
    int  mem_lat = 1;
    bit  spur_en = 1'b0;
    int  pend_addr [$];
    int  pend_due  [$];
    int  rd_log    [$];
    int  mcyc = 0;

    input_fetcher dut (
        .clock        (clock),
        .reset        (reset),
        .input_req    (input_req),
        .width_index  (width_index),
        .height_index (height_index),
        .input_ready  (input_ready),
        .window_data  (window_data),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory: a strobe seen in cycle t is answered in cycle t+mem_lat-1, so the
    // fetcher captures it mem_lat edges after the edge that raised the strobe.
    always begin
        @(posedge clock);
        #1;
        mem_rd_valid = 1'b0;
        mem_rd_data  = DW'($urandom);
        if (mem_rd_en) begin
            chk("outstanding", 128'(pend_addr.size()), 128'(0));
            rd_log.push_back(int'(mem_addr));
            pend_addr.push_back(int'(mem_addr));
            pend_due.push_back(mcyc + mem_lat - 1);
        end
        if (pend_due.size() > 0 && pend_due[0] == mcyc) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mem[pend_addr[0]];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else if (spur_en && pend_due.size() == 0 && !mem_rd_en && $urandom_range(0, 2) == 0) begin
            mem_rd_valid = 1'b1;
        end
        mcyc++;
    end

    // One full request: hold < 0 drops input_req right after acceptance,
    // otherwise input_req stays high for hold cycles of input_ready.
    task automatic do_fetch(input int wi, input int hi, input int lat, input bit spur, input int hold);
        logic [WIN_W-1:0] exp_win;
        int exp_lat;
        int exp_addr [$];
        int n;
        int r;
        int c;
        int nrd;
        exp_win = '0;
        exp_lat = 1;
        for (int k = 0; k < int'(K * K); k++) begin
            r = hi + k / int'(K);
            c = wi + k % int'(K);
            if (r < int'(IH) && c < int'(IW)) begin
                exp_addr.push_back(r * int'(IW) + c);
                exp_win[k*DW +: DW] = mem[r * int'(IW) + c];
                exp_lat += 1 + lat;
            end else begin
                exp_lat += 1;
            end
        end
        mem_lat = lat;
        spur_en = spur;
        rd_log.delete();
        input_req    = 1'b1;
        width_index  = 4'(wi);
        height_index = 4'(hi);
        @(posedge clock);
        #1;
        if (hold < 0) input_req = 1'b0;
        n = 0;
        while (!input_ready && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("latency", 128'(n), 128'(exp_lat));
        chk("window", 128'(window_data), 128'(exp_win));
        chk("nreads", 128'(rd_log.size()), 128'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < rd_log.size(); i++) begin
            chk("addr", 128'(rd_log[i]), 128'(exp_addr[i]));
        end
        if (hold < 0) begin
            @(posedge clock);
            #1;
            chk("ready_pulse_end", 128'(input_ready), 128'(0));
        end else begin
            nrd = rd_log.size();
            for (int i = 0; i < hold; i++) begin
                @(posedge clock);
                #1;
                chk("ready_held", 128'(input_ready), 128'(1));
                chk("window_stable", 128'(window_data), 128'(exp_win));
            end
            chk("no_reads_in_ready", 128'(rd_log.size()), 128'(nrd));
            input_req = 1'b0;
            @(posedge clock);
            #1;
            chk("ready_after_drop", 128'(input_ready), 128'(1));
            @(posedge clock);
            #1;
            chk("ready_dropped", 128'(input_ready), 128'(0));
        end
        spur_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int a = 0; a < 256; a++) mem[a] = DW'(a);
        #3;
        chk("rst_ready", 128'(input_ready), 128'(0));
        chk("rst_rd_en", 128'(mem_rd_en), 128'(0));
        chk("rst_addr", 128'(mem_addr), 128'(0));
        chk("rst_window", 128'(window_data), 128'(0));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Interior window, identity memory, latency 1.
        do_fetch(2, 3, 1, 1'b0, 0);
        // Bottom-right corner: one real read, eight padded words.
        do_fetch(15, 15, 1, 1'b0, 0);

        for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
        // Handshake held for four READY cycles.
        do_fetch(7, 4, 2, 1'b0, 4);
        // Latency 3 with spurious returns while no read is outstanding.
        do_fetch(1, 9, 3, 1'b1, 1);
        // Request withdrawn before the window is complete.
        do_fetch(14, 0, 2, 1'b0, -1);

        // Reset while the fourth read is outstanding.
        mem_lat = 3;
        rd_log.delete();
        input_req    = 1'b1;
        width_index  = 4'd5;
        height_index = 4'd5;
        n = 0;
        while (rd_log.size() < 4 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("reads_before_reset", 128'(rd_log.size()), 128'(4));
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 128'(input_ready), 128'(0));
        chk("mid_rst_rd_en", 128'(mem_rd_en), 128'(0));
        chk("mid_rst_addr", 128'(mem_addr), 128'(0));
        chk("mid_rst_window", 128'(window_data), 128'(0));
        input_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        chk("stale_return_ready", 128'(input_ready), 128'(0));
        chk("stale_return_window", 128'(window_data), 128'(0));
        do_fetch(5, 5, 3, 1'b0, 0);

        // Controller-style walk over every window position.
        for (int h = 0; h < int'(IH); h++) begin
            for (int w = 0; w < int'(IW); w++) begin
                do_fetch(w, h, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
